// File: rtl/ratio_sine_scaler.sv
// Computes y = a/(a+b+c) * sin(2*pi*phase/1024) as one sequenced operation.
// The phase arrives serially on e. The result is a 14-bit two's-complement value with a start/busy/done handshake.
module ratio_sine_scaler #(
    parameter int DW = 12,
    parameter int FW = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] c,
    input  logic          e,
    output logic          busy,
    output logic          done,
    output logic          div0,
    output logic [13:0]   y
);

    localparam int  CW = $clog2(FW + 1);
    localparam real PI = 3.14159265358979323846;

    if (FW < 9) begin : g_fw_check
        $error("ratio_sine_scaler: FW must be >= 9");
    end

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_SINE, S_MUL} state_t;

    state_t          state_q;
    logic [DW+1:0]   s_q;
    logic [DW+2:0]   r_q;
    logic [FW:0]     quo_q;
    logic [CW-1:0]   cnt_q;
    logic [9:0]      phase_q;
    logic [12:0]     mag_q;
    logic            sign_q;
    logic            busy_q, done_q, div0_q;
    logic [13:0]     y_q;

    // Quarter-wave table: round(8191*sin(pi*i/512)) for i = 0..256.
    logic [12:0] sin_lut [0:256];
    for (genvar i = 0; i <= 256; i++) begin : g_lut
        localparam int VAL = $rtoi(8191.0 * $sin(PI * i / 512.0) + 0.5);
        assign sin_lut[i] = 13'(VAL);
    end

    logic [DW+1:0] sum_d;
    logic          q_bit;
    logic [DW+2:0] r_d;
    logic [FW:0]   quo_d;
    logic [8:0]    idx_d;
    logic [12:0]   mag_d;
    logic          sign_d;
    logic [12:0]   p_d;
    logic [13:0]   y_d;

    always_comb begin
        sum_d  = (DW+2)'(a) + (DW+2)'(b) + (DW+2)'(c);
        // A zero divisor would yield all-ones, so the quotient is forced to zero.
        q_bit  = (s_q != '0) && (r_q >= {1'b0, s_q});
        r_d    = (q_bit ? (r_q - {1'b0, s_q}) : r_q) << 1;
        quo_d  = {quo_q[FW-1:0], q_bit};
        // Fold the 0..511 half-wave onto the 0..256 quarter table.
        idx_d  = (phase_q[8:0] <= 9'd256) ? phase_q[8:0] : 9'(10'd512 - {1'b0, phase_q[8:0]});
        mag_d  = sin_lut[idx_d];
        sign_d = (phase_q > 10'd512);
        p_d    = 13'(({{13{1'b0}}, quo_q} * {{(FW+1){1'b0}}, mag_q}) >> FW);
        y_d    = sign_q ? (14'd0 - {1'b0, p_d}) : {1'b0, p_d};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            s_q     <= '0;
            r_q     <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            phase_q <= '0;
            mag_q   <= '0;
            sign_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
            y_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        s_q     <= sum_d;
                        r_q     <= (DW+3)'(a);
                        quo_q   <= '0;
                        cnt_q   <= '0;
                        phase_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_DIV;
                    end
                end
                S_DIV: begin
                    r_q   <= r_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q < CW'(10)) phase_q <= {phase_q[8:0], e};
                    if (cnt_q == CW'(FW)) state_q <= S_SINE;
                end
                S_SINE: begin
                    mag_q   <= mag_d;
                    sign_q  <= sign_d;
                    state_q <= S_MUL;
                end
                S_MUL: begin
                    y_q     <= y_d;
                    div0_q  <= (s_q == '0);
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign div0 = div0_q;
    assign y    = y_q;

endmodule

// File: tb/tb_ratio_sine_scaler.sv
// Directed bench for ratio_sine_scaler: latency, sign folding, full scale, div0, back-to-back, reset.
module tb_ratio_sine_scaler;

    logic        clk = 1'b0;
    logic        rst, start, e;
    logic [11:0] a, b, c;
    logic        busy, done, div0;
    logic [13:0] y;

    int n_checks = 0;
    int n_fail   = 0;

    ratio_sine_scaler #(.DW(12), .FW(14)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c), .e(e),
        .busy(busy), .done(done), .div0(div0), .y(y)
    );

    always #5 clk = ~clk;

    // Runs one operation; returns with the bench 1 time unit after the edge that raised done.
    task automatic do_op(input logic [11:0] ta, input logic [11:0] tb_, input logic [11:0] tc,
                         input logic [9:0] ph, input bit b2b, input bit noisy, output int lat);
        int edges;
        if (!b2b) @(negedge clk);
        a = ta; b = tb_; c = tc; start = 1'b1; e = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL accept: busy=%b done=%b, required busy=1 done=0", busy, done);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = noisy;
            if (noisy) begin a = 12'($urandom); b = 12'($urandom); c = 12'($urandom); end
            e = ph[9-i];
            @(posedge clk);
        end
        edges = 10;
        lat = -1;
        while (edges < 40) begin
            #1;
            if (done === 1'b1) begin lat = edges; break; end
            @(negedge clk);
            start = noisy;
            e = 1'($urandom_range(0, 1));
            if (noisy) begin a = 12'($urandom); b = 12'($urandom); c = 12'($urandom); end
            @(posedge clk);
            edges++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; e = 1'b0; a = '0; b = '0; c = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, div0, y} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b div0=%b y=%h, required all 0", busy, done, div0, y);
        end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat;
        do_op(12'd100, 12'd100, 12'd200, 10'd256, 1'b0, 1'b0, lat);
        n_checks++;
        if (lat !== 17) begin n_fail++; $display("FAIL basic_latency: got %0d, required 17", lat); end
        n_checks++;
        if (y !== 14'h07FF || div0 !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: y=%h div0=%b busy=%b, required y=07ff div0=0 busy=0", y, div0, busy);
        end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || y !== 14'h07FF) begin
            n_fail++;
            $display("FAIL done_pulse: done=%b y=%h, required done=0 y=07ff", done, y);
        end
    endtask

    task automatic test_negative();
        int lat;
        do_op(12'd100, 12'd100, 12'd200, 10'd768, 1'b0, 1'b0, lat);
        n_checks++;
        if (lat !== 17 || y !== 14'h3801) begin
            n_fail++;
            $display("FAIL negative: lat=%0d y=%h, required lat=17 y=3801", lat, y);
        end
    endtask

    task automatic test_full_scale();
        int lat;
        do_op(12'd4095, 12'd0, 12'd0, 10'd256, 1'b0, 1'b0, lat);
        n_checks++;
        if (lat !== 17 || y !== 14'h1FFF || div0 !== 1'b0) begin
            n_fail++;
            $display("FAIL full_scale: lat=%0d y=%h div0=%b, required lat=17 y=1fff div0=0", lat, y, div0);
        end
    endtask

    task automatic test_div0();
        int lat;
        do_op(12'd0, 12'd0, 12'd0, 10'd300, 1'b0, 1'b0, lat);
        n_checks++;
        if (lat !== 17 || y !== 14'h0000 || div0 !== 1'b1) begin
            n_fail++;
            $display("FAIL div0: lat=%0d y=%h div0=%b, required lat=17 y=0000 div0=1", lat, y, div0);
        end
    endtask

    task automatic test_zero_phase();
        int lat;
        do_op(12'd1, 12'd1, 12'd1, 10'd0, 1'b0, 1'b0, lat);
        n_checks++;
        if (lat !== 17 || y !== 14'h0000 || div0 !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_phase: lat=%0d y=%h div0=%b, required lat=17 y=0000 div0=0", lat, y, div0);
        end
    endtask

    // q = 4096 (ratio 1/4); |sin(45 deg)| gives mag 5792 -> p = 1448.
    task automatic test_quadrants();
        logic [9:0]  ph_tab [4] = '{10'd128, 10'd384, 10'd512, 10'd640};
        logic [13:0] y_tab  [4] = '{14'd1448, 14'd1448, 14'd0, 14'h3A58};
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_op(12'd1, 12'd1, 12'd2, ph_tab[i], 1'b0, 1'b0, lat);
            n_checks++;
            if (lat !== 17 || y !== y_tab[i]) begin
                n_fail++;
                $display("FAIL quadrant_%0d: phase=%0d lat=%0d y=%h, required lat=17 y=%h",
                         i, ph_tab[i], lat, y, y_tab[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2;
        do_op(12'd4095, 12'd0, 12'd0, 10'd256, 1'b0, 1'b0, lat1);
        do_op(12'd100, 12'd100, 12'd200, 10'd768, 1'b1, 1'b0, lat2);
        n_checks++;
        if (lat1 !== 17 || lat2 !== 17 || y !== 14'h3801) begin
            n_fail++;
            $display("FAIL back_to_back: lat1=%0d lat2=%0d y=%h, required 17 17 3801", lat1, lat2, y);
        end
    endtask

    task automatic test_start_while_busy();
        int lat;
        int extra;
        do_op(12'd100, 12'd100, 12'd200, 10'd256, 1'b0, 1'b1, lat);
        n_checks++;
        if (lat !== 17 || y !== 14'h07FF || div0 !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_start_result: lat=%0d y=%h div0=%b, required 17 07ff 0", lat, y, div0);
        end
        extra = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        n_checks++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL busy_start_queued: %0d busy/done cycles after op, required 0", extra);
        end
    endtask

    task automatic test_reset_mid_div();
        int lat;
        int seen;
        @(negedge clk);
        a = 12'd100; b = 12'd100; c = 12'd200; start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, div0, y} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_mid_div: busy=%b done=%b div0=%b y=%h, required all 0", busy, done, div0, y);
        end
        @(negedge clk) rst = 1'b0;
        seen = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done === 1'b1 || y !== 14'd0) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL reset_discard: %0d cycles with done or nonzero y, required 0", seen);
        end
        do_op(12'd100, 12'd100, 12'd200, 10'd256, 1'b0, 1'b0, lat);
        n_checks++;
        if (lat !== 17 || y !== 14'h07FF) begin
            n_fail++;
            $display("FAIL after_reset_op: lat=%0d y=%h, required 17 07ff", lat, y);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_full_scale();
        test_div0();
        test_zero_phase();
        test_quadrants();
        test_back_to_back();
        test_start_while_busy();
        test_quadrants();
        test_reset_mid_div();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
